yazmac_skorbord: RTL

- Parametrised register scoreboard and hazard/forwarding controller for the back end; next generation of the hazard unit between decode/register-read and execute.
- Tracks in-flight register writes from BIRIM_SAYISI variable-latency execution units (ALU, multiplier, divider, memory unit, ...).
- Stalls the decode/register-read stage on RAW, WAW and structural hazards.
- Selects per-source forwarding from unit result buses on the completion cycle.

---
 rtl/yazmac_skorbord_pkg.sv | 24 ++
 rtl/yazmac_skorbord_kaynak_denetle.sv | 46 ++++
 rtl/yazmac_skorbord.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/yazmac_skorbord_pkg.sv
// ---------------------------------------------------------------------------
// yazmac_skorbord_pkg
// Shared definitions for the register scoreboard / hazard controller.
//   - Execution unit codes (tag values driven on cyo_birim_i).
//   - Default tag width and a helper that derives the tag width from the
//     unit count.
// ---------------------------------------------------------------------------
package yazmac_skorbord_pkg;

    // Execution unit codes
    localparam int BIRIM_ALU  = 0;
    localparam int BIRIM_CARP = 1;
    localparam int BIRIM_BOL  = 2;
    localparam int BIRIM_BIB  = 3;

    localparam int ETIKET_BIT_VARSAYILAN = 2;

    // Tag width for a given unit count; at least one bit, because two units
    // is the smallest legal configuration.
    function automatic int etiket_genislik(input int birim_sayisi);
        return (birim_sayisi <= 2) ? 1 : $clog2(birim_sayisi);
    endfunction

endpackage

// File: rtl/yazmac_skorbord_kaynak_denetle.sv
// ---------------------------------------------------------------------------
// skorbord_kaynak_denetle
// Combinational hazard check for one source operand.
// Ports:
//   kullan    in   instruction reads this source
//   adres     in   source register address (x0 never stalls or forwards)
//   bekliyor  in   scoreboard pending bit of that register
//   etiket    in   unit that will write that register
//   bitti     in   per-unit "completes this cycle" vector, already masked
//                  with the unit busy bits, padded to 2**ETIKET_BIT
//   durdur    out  RAW stall
//   yonlendir out  take the operand from a result bus
//   birim     out  unit whose result bus supplies the operand (0 otherwise)
// ---------------------------------------------------------------------------
module skorbord_kaynak_denetle
    import yazmac_skorbord_pkg::*;
#(
    parameter int ADRES_BIT  = 5,
    parameter int ETIKET_BIT = ETIKET_BIT_VARSAYILAN
) (
    input  logic                        kullan,
    input  logic [ADRES_BIT-1:0]        adres,
    input  logic                        bekliyor,
    input  logic [ETIKET_BIT-1:0]       etiket,
    input  logic [(1<<ETIKET_BIT)-1:0]  bitti,
    output logic                        durdur,
    output logic                        yonlendir,
    output logic [ETIKET_BIT-1:0]       birim
);

    always_comb begin
        durdur    = 1'b0;
        yonlendir = 1'b0;
        birim     = '0;
        if (kullan && (adres != '0) && bekliyor) begin
            if (bitti[etiket]) begin
                // Producer writes back this very cycle: take its result bus.
                yonlendir = 1'b1;
                birim     = etiket;
            end else begin
                durdur = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yazmac_skorbord.sv
// ---------------------------------------------------------------------------
// yazmac_skorbord
// Register scoreboard and hazard/forwarding controller sitting between
// decode/register-read and the execution units. Each unit has at most one
// operation in flight; each architectural register (except x0) records
// whether a write is pending and which unit will produce it.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   cyo_gecerli_i                 decode stage holds a valid instruction
//   cyo_rs1/rs2_adres_i, _kullan_i source addresses and use flags
//   cyo_rd_adres_i, cyo_yaz_yazmac_i destination address and write flag
//   cyo_birim_i                   target execution unit
//   ddb_durdur_i                  external stall
//   ddb_bosalt_i                  kill the decode-stage instruction
//   yrt_bitti_i                   per-unit write-back this cycle
//   cyo_durdur_o, cyo_verildi_o   hold decode / instruction issued
//   cyo_yonlendir{1,2}_o, cyo_yonlendir_birim{1,2}_o  forwarding selects
//   birim_mesgul_o, bos_o         unit busy vector / nothing in flight
// ---------------------------------------------------------------------------
module yazmac_skorbord
    import yazmac_skorbord_pkg::*;
#(
    parameter int YAZMAC_SAYISI = 32,
    parameter int ADRES_BIT     = $clog2(YAZMAC_SAYISI),
    parameter int BIRIM_SAYISI  = 4,
    parameter int ETIKET_BIT    = etiket_genislik(BIRIM_SAYISI)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyo_gecerli_i,
    input  logic [ADRES_BIT-1:0]    cyo_rs1_adres_i,
    input  logic [ADRES_BIT-1:0]    cyo_rs2_adres_i,
    input  logic                    cyo_rs1_kullan_i,
    input  logic                    cyo_rs2_kullan_i,
    input  logic [ADRES_BIT-1:0]    cyo_rd_adres_i,
    input  logic                    cyo_yaz_yazmac_i,
    input  logic [ETIKET_BIT-1:0]   cyo_birim_i,
    input  logic                    ddb_durdur_i,
    input  logic                    ddb_bosalt_i,
    input  logic [BIRIM_SAYISI-1:0] yrt_bitti_i,
    output logic                    cyo_durdur_o,
    output logic                    cyo_verildi_o,
    output logic                    cyo_yonlendir1_o,
    output logic [ETIKET_BIT-1:0]   cyo_yonlendir_birim1_o,
    output logic                    cyo_yonlendir2_o,
    output logic [ETIKET_BIT-1:0]   cyo_yonlendir_birim2_o,
    output logic [BIRIM_SAYISI-1:0] birim_mesgul_o,
    output logic                    bos_o
);

    localparam int ETIKET_SAYISI = 1 << ETIKET_BIT;

    // Scoreboard state. Bit 0 of bekliyor_reg is never set, so x0 reads as
    // "not pending" without extra address checks on the read side.
    logic [YAZMAC_SAYISI-1:0] bekliyor_reg;
    logic [ETIKET_BIT-1:0]    etiket_reg [YAZMAC_SAYISI];
    logic [BIRIM_SAYISI-1:0]  mesgul_reg;

    // Unit vectors padded to the full tag range so any tag value can index
    // them; codes beyond BIRIM_SAYISI read as idle / not completing.
    logic [BIRIM_SAYISI-1:0]  bitti;
    logic [ETIKET_SAYISI-1:0] bitti_gen;
    logic [ETIKET_SAYISI-1:0] mesgul_gen;

    always_comb begin
        bitti      = yrt_bitti_i & mesgul_reg;   // completions of idle units are ignored
        bitti_gen  = '0;
        mesgul_gen = '0;
        bitti_gen[BIRIM_SAYISI-1:0]  = bitti;
        mesgul_gen[BIRIM_SAYISI-1:0] = mesgul_reg;
    end

    // ---------------------------------------------------------------- hazards
    logic                  raw1, raw2;
    logic                  yon1, yon2;
    logic [ETIKET_BIT-1:0] yon_birim1, yon_birim2;
    logic                  waw, yapisal, aktif, durdur, verildi;

    skorbord_kaynak_denetle #(
        .ADRES_BIT (ADRES_BIT),
        .ETIKET_BIT(ETIKET_BIT)
    ) u_kaynak1 (
        .kullan   (cyo_rs1_kullan_i),
        .adres    (cyo_rs1_adres_i),
        .bekliyor (bekliyor_reg[cyo_rs1_adres_i]),
        .etiket   (etiket_reg[cyo_rs1_adres_i]),
        .bitti    (bitti_gen),
        .durdur   (raw1),
        .yonlendir(yon1),
        .birim    (yon_birim1)
    );

    skorbord_kaynak_denetle #(
        .ADRES_BIT (ADRES_BIT),
        .ETIKET_BIT(ETIKET_BIT)
    ) u_kaynak2 (
        .kullan   (cyo_rs2_kullan_i),
        .adres    (cyo_rs2_adres_i),
        .bekliyor (bekliyor_reg[cyo_rs2_adres_i]),
        .etiket   (etiket_reg[cyo_rs2_adres_i]),
        .bitti    (bitti_gen),
        .durdur   (raw2),
        .yonlendir(yon2),
        .birim    (yon_birim2)
    );

    always_comb begin
        // A pending rd whose producer finishes now frees up: the new write
        // is younger and takes over the entry at the clock edge.
        waw     = cyo_yaz_yazmac_i && (cyo_rd_adres_i != '0)
                  && bekliyor_reg[cyo_rd_adres_i]
                  && !bitti_gen[etiket_reg[cyo_rd_adres_i]];
        yapisal = mesgul_gen[cyo_birim_i] && !bitti_gen[cyo_birim_i];
        aktif   = cyo_gecerli_i && !ddb_bosalt_i;
        durdur  = aktif && (raw1 || raw2 || waw || yapisal || ddb_durdur_i);
        verildi = aktif && !durdur;
    end

    assign cyo_durdur_o           = durdur;
    assign cyo_verildi_o          = verildi;
    assign cyo_yonlendir1_o       = cyo_gecerli_i & yon1;
    assign cyo_yonlendir_birim1_o = cyo_gecerli_i ? yon_birim1 : '0;
    assign cyo_yonlendir2_o       = cyo_gecerli_i & yon2;
    assign cyo_yonlendir_birim2_o = cyo_gecerli_i ? yon_birim2 : '0;
    assign birim_mesgul_o         = mesgul_reg;
    assign bos_o                  = ~|mesgul_reg;

    // ------------------------------------------------------ next-state terms
    logic [YAZMAC_SAYISI-1:0] yazmac_kur;   // issue marks register pending
    logic [YAZMAC_SAYISI-1:0] yazmac_sil;   // producer completes this cycle
    logic [BIRIM_SAYISI-1:0]  mesgul_kur;   // issue occupies unit

    genvar gi;
    generate
        for (gi = 0; gi < YAZMAC_SAYISI; gi++) begin : g_yazmac
            if (gi == 0) begin : g_sifir
                assign yazmac_kur[gi] = 1'b0;
                assign yazmac_sil[gi] = 1'b0;
            end else begin : g_iz
                assign yazmac_kur[gi] = verildi && cyo_yaz_yazmac_i
                                        && (cyo_rd_adres_i == ADRES_BIT'(gi));
                assign yazmac_sil[gi] = bitti_gen[etiket_reg[gi]];
            end
        end

        for (gi = 0; gi < BIRIM_SAYISI; gi++) begin : g_birim
            assign mesgul_kur[gi] = verildi && (cyo_birim_i == ETIKET_BIT'(gi));
        end
    endgenerate

    // Set beats clear: an issue and a completion on the same unit/register
    // in one cycle leave the entry busy for the new operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bekliyor_reg <= '0;
            mesgul_reg   <= '0;
            for (int r = 0; r < YAZMAC_SAYISI; r++) begin
                etiket_reg[r] <= '0;
            end
        end else begin
            mesgul_reg   <= (mesgul_reg & ~bitti) | mesgul_kur;
            bekliyor_reg <= (bekliyor_reg & ~yazmac_sil) | yazmac_kur;
            for (int r = 0; r < YAZMAC_SAYISI; r++) begin
                if (yazmac_kur[r]) begin
                    etiket_reg[r] <= cyo_birim_i;
                end
            end
        end
    end

endmodule
